// File: rtl/calib_pulse_seq.sv
// calib_pulse_seq: burst calibration pulse sequencer.
// Each START issues a burst of shots. Every shot drives NCH delayed channel strobes,
// one calibration LCT and one calibration L1A, each timed from a shared shot timer.
// Optional feature macro: CALIB_PULSE_SEQ_RNDM_EN. When it is defined, RNDMGTRG is
// ORed into CAL_GTRG in every state.
// Every output is registered. Each one is computed from the next state and next timer
// value, so a strobe appears in the same cycle as the timer value it belongs to.
module calib_pulse_seq #(
  parameter int NCH  = 2,
  parameter int DLYW = 5,
  parameter int LCTW = 6,
  parameter int L1AW = 9,
  parameter int BCW  = 8,
  parameter int PERW = 12
) (
  input  logic                CLKCMS,
  input  logic                RST_N,
  input  logic                START,
  input  logic                ABORT,
  input  logic [NCH-1:0]      CH_EN,
  input  logic [NCH*DLYW-1:0] CH_DLY,
  input  logic [LCTW-1:0]     LCT_DLY,
  input  logic [L1AW-1:0]     L1A_DLY,
  input  logic [BCW-1:0]      BURST_N,
  input  logic [PERW-1:0]     BURST_PER,
  input  logic                RNDMGTRG,
  output logic                BUSY,
  output logic                SYNCIP,
  output logic [NCH-1:0]      CH_PLS,
  output logic                CALLCT,
  output logic                CAL_GTRG,
  output logic [BCW-1:0]      SHOT_CNT,
  output logic                DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e state_q, state_d;
  logic [PERW-1:0] t_q, t_d;

  // Shadow copies of the burst configuration, captured when a burst is accepted
  logic [NCH-1:0]      en_q, en_d;
  logic [NCH*DLYW-1:0] dly_q, dly_d;
  logic [LCTW-1:0]     lct_q, lct_d;
  logic [L1AW-1:0]     l1a_q, l1a_d;
  logic [BCW-1:0]      bn_q, bn_d;
  logic [PERW-1:0]     per_q, per_d;

  logic           busy_q, busy_d, syncip_q, syncip_d, callct_q, callct_d;
  logic           gtrg_q, gtrg_d, done_q, done_d, seq_l1a, run_d;
  logic [NCH-1:0] ch_pls_q, ch_pls_d;
  logic [BCW-1:0] shot_cnt_q, shot_cnt_d;
  logic           accept;

  // ABORT has priority over START in IDLE
  assign accept = (state_q == S_IDLE) && START && !ABORT;

`ifndef CALIB_PULSE_SEQ_RNDM_EN
  logic unused_rndm;
  assign unused_rndm = RNDMGTRG;
`endif

  // Load the shadow registers only when a burst is accepted
  always_comb begin
    en_d  = accept ? CH_EN     : en_q;
    dly_d = accept ? CH_DLY    : dly_q;
    lct_d = accept ? LCT_DLY   : lct_q;
    l1a_d = accept ? L1A_DLY   : l1a_q;
    bn_d  = accept ? BURST_N   : bn_q;
    per_d = accept ? BURST_PER : per_q;
  end

  // State register
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and shot timer. The timer wraps at P, and the last shot moves to FIN.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_RUN;
        t_d     = '0;
      end
      S_RUN: begin
        if (ABORT) begin
          state_d = S_IDLE;
          t_d     = '0;
        end else if (t_q == per_q) begin
          t_d = '0;
          if (shot_cnt_q == bn_q && bn_q != '0) state_d = S_FIN;
        end else begin
          t_d = t_q + PERW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Output decode from the next state and timer value. A delay larger than P never matches.
  always_comb begin
    run_d    = (state_d == S_RUN);
    busy_d   = run_d;
    syncip_d = run_d && (t_d == '0);
    ch_pls_d = '0;
    for (int i = 0; i < NCH; i++)
      ch_pls_d[i] = run_d && en_d[i] && (32'(dly_d[i*DLYW +: DLYW]) == 32'(t_d));
    callct_d = run_d && (32'(lct_d) == 32'(t_d));
    seq_l1a  = run_d && (32'(l1a_d) == 32'(t_d));
`ifdef CALIB_PULSE_SEQ_RNDM_EN
    gtrg_d   = seq_l1a | RNDMGTRG;
`else
    gtrg_d   = seq_l1a;
`endif
    done_d     = (state_d == S_FIN);
    shot_cnt_d = (accept ? '0 : shot_cnt_q) + BCW'(syncip_d);
  end

  // Datapath and output registers
  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      t_q        <= '0;
      en_q       <= '0;
      dly_q      <= '0;
      lct_q      <= '0;
      l1a_q      <= '0;
      bn_q       <= '0;
      per_q      <= '0;
      busy_q     <= 1'b0;
      syncip_q   <= 1'b0;
      ch_pls_q   <= '0;
      callct_q   <= 1'b0;
      gtrg_q     <= 1'b0;
      done_q     <= 1'b0;
      shot_cnt_q <= '0;
    end else begin
      t_q        <= t_d;
      en_q       <= en_d;
      dly_q      <= dly_d;
      lct_q      <= lct_d;
      l1a_q      <= l1a_d;
      bn_q       <= bn_d;
      per_q      <= per_d;
      busy_q     <= busy_d;
      syncip_q   <= syncip_d;
      ch_pls_q   <= ch_pls_d;
      callct_q   <= callct_d;
      gtrg_q     <= gtrg_d;
      done_q     <= done_d;
      shot_cnt_q <= shot_cnt_d;
    end
  end

  assign BUSY     = busy_q;
  assign SYNCIP   = syncip_q;
  assign CH_PLS   = ch_pls_q;
  assign CALLCT   = callct_q;
  assign CAL_GTRG = gtrg_q;
  assign DONE     = done_q;
  assign SHOT_CNT = shot_cnt_q;

endmodule

// File: tb/tb_calib_pulse_seq.sv
// Directed bench for calib_pulse_seq. Cycle n is the interval after clock edge n-1.
// Outputs are sampled 1 time unit after each rising edge.
module tb_calib_pulse_seq;
  localparam int NCH = 2, DLYW = 5, LCTW = 6, L1AW = 9, BCW = 8, PERW = 12;

  logic                CLKCMS = 1'b0, RST_N = 1'b0, START = 1'b0, ABORT = 1'b0, RNDMGTRG = 1'b0;
  logic [NCH-1:0]      CH_EN = '0;
  logic [NCH*DLYW-1:0] CH_DLY = '0;
  logic [LCTW-1:0]     LCT_DLY = '0;
  logic [L1AW-1:0]     L1A_DLY = '0;
  logic [BCW-1:0]      BURST_N = '0;
  logic [PERW-1:0]     BURST_PER = '0;
  logic                BUSY, SYNCIP, CALLCT, CAL_GTRG, DONE;
  logic [NCH-1:0]      CH_PLS;
  logic [BCW-1:0]      SHOT_CNT;

  int nvec = 0, nerr = 0, cyc = 0, r = 0;

  always #5 CLKCMS = ~CLKCMS;

  calib_pulse_seq #(.NCH(NCH), .DLYW(DLYW), .LCTW(LCTW), .L1AW(L1AW), .BCW(BCW), .PERW(PERW)) dut (
    .CLKCMS(CLKCMS), .RST_N(RST_N), .START(START), .ABORT(ABORT), .CH_EN(CH_EN),
    .CH_DLY(CH_DLY), .LCT_DLY(LCT_DLY), .L1A_DLY(L1A_DLY), .BURST_N(BURST_N),
    .BURST_PER(BURST_PER), .RNDMGTRG(RNDMGTRG), .BUSY(BUSY), .SYNCIP(SYNCIP),
    .CH_PLS(CH_PLS), .CALLCT(CALLCT), .CAL_GTRG(CAL_GTRG), .SHOT_CNT(SHOT_CNT), .DONE(DONE)
  );

  task automatic tick();
    @(posedge CLKCMS);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Packed view of the strobe outputs: {BUSY, SYNCIP, CH_PLS[1], CH_PLS[0], CALLCT, CAL_GTRG, DONE}
  function automatic logic [6:0] obs();
    return {BUSY, SYNCIP, CH_PLS, CALLCT, CAL_GTRG, DONE};
  endfunction

  function automatic logic [6:0] ex(bit b, bit s, bit p1, bit p0, bit l, bit g, bit d);
    return {b, s, p1, p0, l, g, d};
  endfunction

  // START is sampled at edge 10. Expected: SYNCIP at 11, CH_PLS[1] at 14, CH_PLS[0] at 18,
  // CALLCT at 16, CAL_GTRG at 30, DONE at 32, and BUSY high for cycles 11..31.
  task automatic single_shot(input string tag);
    cyc = 10;
    BURST_N = 1; BURST_PER = 20; CH_EN = 2'b11; CH_DLY = {5'd3, 5'd7};
    LCT_DLY = 5; L1A_DLY = 19; START = 1'b1;
    tick();
    START = 1'b0;
    while (cyc <= 33) begin
      chk(tag, obs(), ex(cyc >= 11 && cyc <= 31, cyc == 11, cyc == 14, cyc == 18,
                         cyc == 16, cyc == 30, cyc == 32));
      tick();
    end
    chk({tag, "_cnt"}, SHOT_CNT, 1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_out", obs(), 7'b0);
    chk("reset_cnt", SHOT_CNT, 0);
    RST_N = 1'b1;
    tick();

    // Single shot
    single_shot("single");

    // Burst of 3 with period 10. The L1A delay of 12 is past P, so CAL_GTRG never fires.
    // The channel delay of 9 equals P, and an LCT delay of 0 lands on SYNCIP.
    cyc = 0;
    BURST_N = 3; BURST_PER = 9; CH_EN = 2'b01; CH_DLY = {5'd0, 5'd9};
    LCT_DLY = 0; L1A_DLY = 12; START = 1'b1;
    tick();
    START = 1'b0;
    for (r = 0; r <= 31; r++) begin
      chk("burst", obs(), ex(r < 30, r == 0 || r == 10 || r == 20, 1'b0,
                             r == 9 || r == 19 || r == 29, r == 0 || r == 10 || r == 20,
                             1'b0, r == 30));
      if (r == 0)  chk("burst_cnt0", SHOT_CNT, 1);
      if (r == 15) chk("burst_cnt1", SHOT_CNT, 2);
      tick();
    end
    chk("burst_cnt", SHOT_CNT, 3);

    // Continuous mode with ABORT at edge c0+12. The LCT at T=3 would be due at c0+13;
    // it must be suppressed.
    BURST_N = 0; BURST_PER = 4; CH_EN = 2'b00; LCT_DLY = 3; L1A_DLY = 100; START = 1'b1;
    tick();
    START = 1'b0;
    for (r = 0; r <= 20; r++) begin
      chk("abort", obs(), ex(r <= 12, r == 0 || r == 5 || r == 10, 1'b0, 1'b0,
                             r == 3 || r == 8, 1'b0, 1'b0));
      if (r == 12) ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
    end
    chk("abort_cnt", SHOT_CNT, 3);

    // START together with ABORT in IDLE: no burst starts, and the count holds
    START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    for (r = 0; r < 3; r++) begin
      chk("start_abort", obs(), 7'b0);
      tick();
    end
    chk("start_abort_cnt", SHOT_CNT, 3);

    // START and new configuration applied mid-burst are both ignored
    BURST_N = 2; BURST_PER = 5; CH_EN = 2'b01; CH_DLY = {5'd0, 5'd2};
    LCT_DLY = 40; L1A_DLY = 300; START = 1'b1;
    tick();
    START = 1'b0;
    for (r = 0; r <= 13; r++) begin
      chk("midburst", obs(), ex(r <= 11, r == 0 || r == 6, 1'b0, r == 2 || r == 8,
                                1'b0, 1'b0, r == 12));
      if (r == 3) begin
        START = 1'b1; CH_DLY = {5'd0, 5'd4}; BURST_PER = 1; BURST_N = 5;
      end else begin
        START = 1'b0;
      end
      tick();
    end
    START = 1'b0;
    chk("midburst_cnt", SHOT_CNT, 2);

    // RNDMGTRG pulse in IDLE
    RNDMGTRG = 1'b1;
    tick();
    RNDMGTRG = 1'b0;
`ifdef CALIB_PULSE_SEQ_RNDM_EN
    chk("rndm", CAL_GTRG, 1);
`else
    chk("rndm", CAL_GTRG, 0);
`endif
    tick();
    chk("rndm_after", CAL_GTRG, 0);

    // Reset mid-burst at cycle c0+6 of the single-shot configuration
    cyc = 10;
    BURST_N = 1; BURST_PER = 20; CH_EN = 2'b11; CH_DLY = {5'd3, 5'd7};
    LCT_DLY = 5; L1A_DLY = 19; START = 1'b1;
    tick();
    START = 1'b0;
    while (cyc < 17) begin
      chk("pre_reset", obs(), ex(1'b1, cyc == 11, cyc == 14, 1'b0, cyc == 16, 1'b0, 1'b0));
      tick();
    end
    RST_N = 1'b0;
    #1;
    chk("async_reset_out", obs(), 7'b0);
    chk("async_reset_cnt", SHOT_CNT, 0);
    tick();
    chk("held_reset_out", obs(), 7'b0);
    RST_N = 1'b1;
    tick();
    single_shot("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
